// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional build macro MDU_FAST_MUL_EN: multiplies complete through a single registered signed product.
module mdu_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             stall
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           op_q, op_d;
    logic                 neg_q, neg_d;
    logic                 rem_neg_q, rem_neg_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     result_q, result_d;

    logic                 s1_sgn, s2_sgn, neg1, neg2;
    logic [WIDTH-1:0]     mag1, mag2;
    logic                 div_zero, div_ovf, special;
    logic [WIDTH-1:0]     special_res;

    logic [WIDTH:0]       mul_sum, div_shrem, div_diff;
    logic                 div_ok;
    logic [2*WIDTH-1:0]   mul_next, div_next, step_next, prod_s;
    logic [WIDTH-1:0]     quot, remv, final_res;
    logic                 last;

`ifdef MDU_FAST_MUL_EN
    logic signed [WIDTH:0]     f1, f2;
    logic signed [2*WIDTH-1:0] fprod;
    logic [WIDTH-1:0]          fast_res;
`endif

    // Operand decode for the request presented in IDLE
    always_comb begin
        unique case (op)
            3'd0, 3'd1, 3'd4, 3'd6: begin s1_sgn = 1'b1; s2_sgn = 1'b1; end
            3'd2:                   begin s1_sgn = 1'b1; s2_sgn = 1'b0; end
            default:                begin s1_sgn = 1'b0; s2_sgn = 1'b0; end
        endcase
        neg1 = s1_sgn & src1[WIDTH-1];
        neg2 = s2_sgn & src2[WIDTH-1];
        mag1 = neg1 ? -src1 : src1;
        mag2 = neg2 ? -src2 : src2;

        div_zero = (src2 == '0);
        div_ovf  = ((op == 3'd4) || (op == 3'd6)) && (src1 == MIN_NEG) && (src2 == '1);
        special  = op[2] & (div_zero | div_ovf);
        // op[1] separates REM/REMU from DIV/DIVU
        if (op[1])
            special_res = div_zero ? src1 : '0;
        else
            special_res = div_zero ? '1 : src1;
    end

`ifdef MDU_FAST_MUL_EN
    always_comb begin
        f1 = {s1_sgn & src1[WIDTH-1], src1};
        f2 = {s2_sgn & src2[WIDTH-1], src2};
        fprod = f1 * f2;
        fast_res = (op == 3'd0) ? fprod[WIDTH-1:0] : fprod[2*WIDTH-1:WIDTH];
    end
`endif

    // One iteration: acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_shrem = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shrem - {1'b0, mcand_q};
        div_ok    = ~div_diff[WIDTH];
        div_next  = {(div_ok ? div_diff[WIDTH-1:0] : div_shrem[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], div_ok};
        step_next = op_q[2] ? div_next : mul_next;

        prod_s = neg_q ? -step_next : step_next;
        quot   = step_next[WIDTH-1:0];
        remv   = step_next[2*WIDTH-1:WIDTH];
        unique case (op_q)
            3'd0:             final_res = prod_s[WIDTH-1:0];
            3'd1, 3'd2, 3'd3: final_res = prod_s[2*WIDTH-1:WIDTH];
            3'd4, 3'd5:       final_res = neg_q ? -quot : quot;
            default:          final_res = rem_neg_q ? -remv : remv;
        endcase
        last = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    if (special) state_d = S_DONE;
`ifdef MDU_FAST_MUL_EN
                    else if (!op[2]) state_d = S_DONE;
`endif
                    else state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (flush)     state_d = S_IDLE;
                else if (last) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy  = (state_q == S_CALC);
        done  = (state_q == S_DONE);
        stall = (start && (state_q == S_IDLE)) || (state_q == S_CALC);
    end

    always_comb begin
        op_d      = op_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    op_d      = op;
                    neg_d     = neg1 ^ neg2;
                    rem_neg_d = neg1;
                    cnt_d     = '0;
                    if (op[2]) begin
                        mcand_d = mag2;
                        acc_d   = {{WIDTH{1'b0}}, mag1};
                    end else begin
                        mcand_d = mag1;
                        acc_d   = {{WIDTH{1'b0}}, mag2};
                    end
                    if (special) result_d = special_res;
`ifdef MDU_FAST_MUL_EN
                    else if (!op[2]) result_d = fast_res;
`endif
                end
            end
            S_CALC: begin
                if (!flush) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    acc_d = step_next;
                    if (last) result_d = final_res;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            mcand_q   <= '0;
            acc_q     <= '0;
            result_q  <= '0;
        end else begin
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
        end
    end

    assign result = result_q;

endmodule
